hazard_unit: RTL

Pipeline hazard controller sitting on the write side of the ID/EX pipeline register. It watches the instruction in ID and the instruction in EX. It drives PC-write, IF/ID-write and the flush/bubble controls that steer what ID/EX latches. Covered events are load-use stalls, taken-branch flushes and the halt-drain sequence, with saturating event counters for the debug unit.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_unit_sat_counter.sv | 29 ++
 rtl/hazard_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the ID/EX hazard controller.
//   state_e          - controller states (RUN, DRAIN, HALTED)
//   DRAIN_CYCLES_DEF - default number of cycles for hlt to drain EX/MEM/WB
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam int unsigned DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
//   clock - rising-edge clock
//   reset - asynchronous active-high clear
//   inc   - count one event this cycle
//   count - current (registered) count
module sat_counter #(
  parameter int unsigned NB_CNT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  output logic [NB_CNT-1:0] count
);

  logic [NB_CNT-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller on the write side of ID/EX.
// Handles load-use stalls, taken-branch flushes and the hlt drain sequence.
//   i_clock, i_reset               - clock, asynchronous active-high reset
//   ID_rs, ID_rt, ID_uses_rt       - source operands of the ID instruction
//   ID_hlt                         - ID instruction is hlt
//   EX_mem_read, EX_rt             - EX instruction is a load into EX_rt
//   EX_branch_taken                - branch in EX resolved taken
//   o_pc_write, o_if_id_write      - PC / IF-ID update enables (combinational)
//   o_if_id_flush, o_id_ex_flush   - nop / bubble insertion (combinational)
//   o_halted                       - pipeline empty after hlt (registered)
//   o_stall_count, o_flush_count   - saturating event counters (registered)
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NB_REG       = 5,
  parameter int unsigned NB_CNT       = 16,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NB_REG-1:0] ID_rs,
  input  logic [NB_REG-1:0] ID_rt,
  input  logic              ID_uses_rt,
  input  logic              ID_hlt,
  input  logic              EX_mem_read,
  input  logic [NB_REG-1:0] EX_rt,
  input  logic              EX_branch_taken,
  output logic              o_pc_write,
  output logic              o_if_id_write,
  output logic              o_if_id_flush,
  output logic              o_id_ex_flush,
  output logic              o_halted,
  output logic [NB_CNT-1:0] o_stall_count,
  output logic [NB_CNT-1:0] o_flush_count
);

  localparam int unsigned NB_DRN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRN-1:0] DRN_LOAD = NB_DRN'(DRAIN_CYCLES - 1);

  state_e            state_q, state_d;
  logic [NB_DRN-1:0] drn_q, drn_d;
  logic              halted_q;
  logic              load_use;
  logic              inc_stall, inc_flush;

  // $0 is never a real destination, so a load into it cannot create a hazard.
  assign load_use = EX_mem_read && (EX_rt != '0) &&
                    ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

  always_comb begin
    state_d       = state_q;
    drn_d         = drn_q;
    o_pc_write    = 1'b0;
    o_if_id_write = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    inc_stall     = 1'b0;
    inc_flush     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (EX_branch_taken) begin
          o_pc_write    = 1'b1;
          o_if_id_write = 1'b1;
          o_if_id_flush = 1'b1;
          o_id_ex_flush = 1'b1;
          inc_flush     = 1'b1;
        end else if (load_use) begin
          o_id_ex_flush = 1'b1;
          inc_stall     = 1'b1;
        end else if (ID_hlt) begin
          // hlt itself enters ID/EX; fetch is frozen from here on.
          state_d = ST_DRAIN;
          drn_d   = DRN_LOAD;
        end else begin
          o_pc_write    = 1'b1;
          o_if_id_write = 1'b1;
        end
      end
      ST_DRAIN: begin
        o_id_ex_flush = 1'b1;
        if (drn_q == '0) state_d = ST_HALTED;
        else             drn_d   = drn_q - 1'b1;
      end
      ST_HALTED: begin
        o_id_ex_flush = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    // Reset forces a nop into both pipeline registers regardless of state.
    if (i_reset) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_RUN;
      drn_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drn_q    <= drn_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  assign o_halted = halted_q;

  sat_counter #(.NB_CNT(NB_CNT)) u_stall_cnt (
    .clock (i_clock),
    .reset (i_reset),
    .inc   (inc_stall),
    .count (o_stall_count)
  );

  sat_counter #(.NB_CNT(NB_CNT)) u_flush_cnt (
    .clock (i_clock),
    .reset (i_reset),
    .inc   (inc_flush),
    .count (o_flush_count)
  );

endmodule
